// File: rtl/tp_mem_pkg.sv
// Shared types and helpers for the two-port byte-enabled memory family.
// The helpers work on a fixed maximum width; callers cast to and from their own DATA_W.
package tp_mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest data bus the helpers can handle.
  localparam int MAX_W  = 1024;
  localparam int MAX_AW = $clog2(MAX_W);

  function automatic logic [MAX_W-1:0] beToMask(input logic [MAX_W-1:0] be,
                                                input int               byteW);
    logic [MAX_W-1:0] mask;
    mask = '0;
    for (int k = 0; k < MAX_W; k++) begin
      mask[MAX_AW'(k)] = be[MAX_AW'(k / byteW)];
    end
    return mask;
  endfunction

  function automatic logic [MAX_W-1:0] mergeBytes(input logic [MAX_W-1:0] oldData,
                                                  input logic [MAX_W-1:0] newData,
                                                  input logic [MAX_W-1:0] mask);
    return (oldData & ~mask) | (newData & mask);
  endfunction

endpackage

// File: rtl/tp_mem_core.sv
// Plain 1-read 1-write byte-enabled array with a registered read port.
// No reset: contents and read register are initialised by the owner.
module tp_mem_core #(
  parameter  int DATA_W = 64,
  parameter  int BYTE_W = 8,
  parameter  int ADDR_W = 8,
  parameter  int DEPTH  = 256,
  localparam int LANES  = DATA_W / BYTE_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LANES-1:0]  i_be,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Read samples the pre-write contents, so a same-address collision is read-first here.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (i_be[i]) begin
          r_mem[i_waddr][i*BYTE_W +: BYTE_W] <= i_wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/tp_mem_1r1w_be_init.sv
// Two-port byte-enabled RAM with a clear engine, selectable read-during-write
// behaviour and an optional output register stage.
module tp_mem_1r1w_be_init
  import tp_mem_pkg::*;
#(
  parameter  int              DATA_W   = 64,
  parameter  int              BYTE_W   = 8,
  parameter  int              ADDR_W   = 8,
  parameter  int              DEPTH    = 256,
  parameter  int              OUT_REG  = 0,
  parameter  int              BYPASS   = 1,
  parameter  logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int              LANES    = DATA_W / BYTE_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  output logic              o_ready,
  input  logic              i_we,
  input  logic [LANES-1:0]  i_be,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_valid_out,
  output logic              o_collision
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  state_t            r_state, w_stateNext;
  logic [ADDR_W-1:0] r_cnt, w_cntNext;

  logic              w_run, w_waddrOk, w_raddrOk, w_userWe, w_userRe, w_collide;
  logic              w_coreWe;
  logic [LANES-1:0]  w_coreBe;
  logic [ADDR_W-1:0] w_coreWaddr;
  logic [DATA_W-1:0] w_coreWdata, w_coreRdata, w_beMask, w_rdata;

  logic              r_rdValid, r_rdColl, r_rdOor, r_hasData;
  logic [DATA_W-1:0] r_bypData, r_bypMask;

  assign w_run     = (r_state == RUN);
  assign w_waddrOk = ({1'b0, i_waddr} < DEPTH_X);
  assign w_raddrOk = ({1'b0, i_raddr} < DEPTH_X);
  assign w_userWe  = w_run & i_we & w_waddrOk;
  assign w_userRe  = w_run & i_re;
  assign w_collide = w_userWe & (i_raddr == i_waddr);
  assign w_beMask  = DATA_W'(beToMask(MAX_W'(i_be), BYTE_W));
  assign o_ready   = w_run;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // A clear request in either state restarts the fill from address 0.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    unique case (r_state)
      INIT: begin
        if (i_clr) begin
          w_cntNext = '0;
        end else if (r_cnt == LAST_ADDR) begin
          w_stateNext = RUN;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + ADDR_W'(1);
        end
      end
      RUN: begin
        if (i_clr) begin
          w_stateNext = INIT;
          w_cntNext   = '0;
        end
      end
    endcase
  end

  always_comb begin
    w_coreWe    = w_userWe;
    w_coreBe    = i_be;
    w_coreWaddr = i_waddr;
    w_coreWdata = i_data_in;
    if (!w_run) begin
      w_coreWe    = 1'b1;
      w_coreBe    = '1;
      w_coreWaddr = r_cnt;
      w_coreWdata = INIT_VAL;
    end
  end

  tp_mem_core #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .i_clk   (i_clk),
    .i_we    (w_coreWe),
    .i_be    (w_coreBe),
    .i_waddr (w_coreWaddr),
    .i_wdata (w_coreWdata),
    .i_re    (w_userRe & w_raddrOk),
    .i_raddr (i_raddr),
    .o_rdata (w_coreRdata)
  );

  // Read side-band state is only updated on a read so data_out holds between reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdValid <= 1'b0;
      r_rdColl  <= 1'b0;
      r_rdOor   <= 1'b0;
      r_hasData <= 1'b0;
      r_bypData <= '0;
      r_bypMask <= '0;
    end else begin
      r_rdValid <= w_userRe;
      if (w_userRe) begin
        r_rdColl  <= w_collide;
        r_rdOor   <= ~w_raddrOk;
        r_hasData <= 1'b1;
        r_bypData <= i_data_in;
        r_bypMask <= w_beMask;
      end
    end
  end

  always_comb begin
    w_rdata = w_coreRdata;
    if (!r_hasData) begin
      w_rdata = '0;
    end else if (r_rdOor) begin
      w_rdata = INIT_VAL;
    end else if ((BYPASS != 0) && r_rdColl) begin
      w_rdata = DATA_W'(mergeBytes(MAX_W'(w_coreRdata), MAX_W'(r_bypData), MAX_W'(r_bypMask)));
    end
  end

  generate
    if (OUT_REG != 0) begin : g_outReg
      logic [DATA_W-1:0] r_dataOut;
      logic              r_validOut, r_collOut;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_dataOut  <= '0;
          r_validOut <= 1'b0;
          r_collOut  <= 1'b0;
        end else begin
          r_validOut <= r_rdValid;
          r_collOut  <= r_rdValid & r_rdColl;
          if (r_rdValid) begin
            r_dataOut <= w_rdata;
          end
        end
      end

      assign o_data_out  = r_dataOut;
      assign o_valid_out = r_validOut;
      assign o_collision = r_collOut;
    end else begin : g_noOutReg
      assign o_data_out  = w_rdata;
      assign o_valid_out = r_rdValid;
      assign o_collision = r_rdValid & r_rdColl;
    end
  endgenerate

endmodule

// File: tb/tb_tp_mem_1r1w_be_init.sv
// Scoreboard bench driving two memory configurations from one stimulus stream:
// A = DEPTH 200, no output register, write-first; B = DEPTH 256, output register, read-first.
module tb_tp_mem_1r1w_be_init;

  localparam logic [63:0] INIT_A = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] INIT_B = 64'h0;

  typedef struct {
    logic [63:0] data;
    logic        coll;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [7:0]  be = '0;
  logic [7:0]  waddr = '0;
  logic [7:0]  raddr = '0;
  logic [63:0] din = '0;

  logic        readyA, validA, collA, readyB, validB, collB;
  logic [63:0] doutA, doutB;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t qA[$];
  exp_t qB[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tp_mem_1r1w_be_init #(
    .DATA_W(64), .BYTE_W(8), .ADDR_W(8), .DEPTH(200),
    .OUT_REG(0), .BYPASS(1), .INIT_VAL(INIT_A)
  ) dutA (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_ready(readyA),
    .i_we(we), .i_be(be), .i_waddr(waddr), .i_data_in(din),
    .i_re(re), .i_raddr(raddr),
    .o_data_out(doutA), .o_valid_out(validA), .o_collision(collA)
  );

  tp_mem_1r1w_be_init #(
    .DATA_W(64), .BYTE_W(8), .ADDR_W(8), .DEPTH(256),
    .OUT_REG(1), .BYPASS(0), .INIT_VAL(INIT_B)
  ) dutB (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_ready(readyB),
    .i_we(we), .i_be(be), .i_waddr(waddr), .i_data_in(din),
    .i_re(re), .i_raddr(raddr),
    .o_data_out(doutB), .o_valid_out(validB), .o_collision(collB)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected responses for a read issued in the current cycle (A: 1 cycle, B: 2 cycles).
  task automatic pushExp(input logic [63:0] eA, input logic cA, input logic [63:0] eB, input logic cB);
    exp_t e;
    e.data = eA; e.coll = cA; e.cyc = cyc + 1;
    qA.push_back(e);
    e.data = eB; e.coll = cB; e.cyc = cyc + 2;
    qB.push_back(e);
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] b, input logic [7:0] wa,
                               input logic [63:0] d, input logic r, input logic [7:0] ra,
                               input logic [63:0] eA, input logic cA,
                               input logic [63:0] eB, input logic cB);
    @(posedge clk);
    #1;
    we = w; be = b; waddr = wa; din = d; re = r; raddr = ra;
    if (r) pushExp(eA, cA, eB, cB);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 8'h00, 64'h0, 1'b0, 8'h00, 64'h0, 1'b0, 64'h0, 1'b0);
  endtask

  // Counts negedges with ready low until both instances are ready; junk accesses
  // are driven for the first junkN cycles and must be ignored while clearing.
  task automatic measureClear(input int junkN, output int cntA, output int cntB);
    cntA = 0;
    cntB = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == junkN) begin
        we = 1'b0;
        re = 1'b0;
      end
      if (!readyA) cntA++;
      if (!readyB) cntB++;
      if (readyA && readyB) break;
    end
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic readAllInit();
    for (int a = 0; a < 256; a++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 64'h0, 1'b1, 8'(a), INIT_A, 1'b0, INIT_B, 1'b0);
    end
    idle(1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && validA) begin
      if (qA.size() == 0) begin
        checkOutput("A unexpected valid_out", 64'(validA), 64'h0);
      end else begin
        e = qA.pop_front();
        checkOutput("A data_out", doutA, e.data);
        checkOutput("A collision", 64'(collA), 64'(e.coll));
        checkOutput("A valid cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && validB) begin
      if (qB.size() == 0) begin
        checkOutput("B unexpected valid_out", 64'(validB), 64'h0);
      end else begin
        e = qB.pop_front();
        checkOutput("B data_out", doutB, e.data);
        checkOutput("B collision", 64'(collB), 64'(e.coll));
        checkOutput("B valid cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int cA, cB;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst readyA", 64'(readyA), 64'h0);
    checkOutput("rst validA", 64'(validA), 64'h0);
    checkOutput("rst collA", 64'(collA), 64'h0);
    checkOutput("rst doutA", doutA, 64'h0);
    checkOutput("rst readyB", 64'(readyB), 64'h0);
    checkOutput("rst validB", 64'(validB), 64'h0);
    checkOutput("rst collB", 64'(collB), 64'h0);
    checkOutput("rst doutB", doutB, 64'h0);

    @(posedge clk);
    #1 rst = 1'b0;
    measureClear(0, cA, cB);
    checkOutput("initial clear cycles A", 64'(cA), 64'd200);
    checkOutput("initial clear cycles B", 64'(cB), 64'd256);

    readAllInit();

    // Back-to-back reads of freshly written words.
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b1, 8'hFF, 8'(a), 64'hC0DE_0000_0000_0000 | 64'(a), 1'b0, 8'h00,
                    64'h0, 1'b0, 64'h0, 1'b0);
    end
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 64'h0, 1'b1, 8'(a),
                    64'hC0DE_0000_0000_0000 | 64'(a), 1'b0,
                    64'hC0DE_0000_0000_0000 | 64'(a), 1'b0);
    end

    // Partial byte-enable update, then a be=0 write that must change nothing.
    applyStimulus(1'b1, 8'hFF, 8'd5, 64'h1122_3344_5566_7788, 1'b0, 8'd0, 64'h0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b1, 8'h0F, 8'd5, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 8'd0, 64'h0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'd5,
                  64'h1122_3344_AAAA_AAAA, 1'b0, 64'h1122_3344_AAAA_AAAA, 1'b0);
    applyStimulus(1'b1, 8'h00, 8'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'd0, 64'h0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'd5,
                  64'h1122_3344_AAAA_AAAA, 1'b0, 64'h1122_3344_AAAA_AAAA, 1'b0);

    // Same-cycle collisions: A is write-first, B is read-first.
    applyStimulus(1'b1, 8'hFF, 8'd9, 64'hDEAD, 1'b1, 8'd9, 64'hDEAD, 1'b1, 64'h0, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'd9, 64'hDEAD, 1'b0, 64'hDEAD, 1'b0);
    applyStimulus(1'b1, 8'h03, 8'd10, 64'hFFFF_FFFF_FFFF_BEEF, 1'b1, 8'd10,
                  64'h5A5A_5A5A_5A5A_BEEF, 1'b1, 64'h0, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'd10,
                  64'h5A5A_5A5A_5A5A_BEEF, 1'b0, 64'h0000_0000_0000_BEEF, 1'b0);

    // Address boundaries: 199 is A's last word, 250 is beyond A but inside B.
    applyStimulus(1'b1, 8'hFF, 8'd199, 64'h99, 1'b0, 8'd0, 64'h0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'd199, 64'h99, 1'b0, 64'h99, 1'b0);
    applyStimulus(1'b1, 8'hFF, 8'd250, 64'h1234, 1'b0, 8'd0, 64'h0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'd250, INIT_A, 1'b0, 64'h1234, 1'b0);
    idle(4);
    @(negedge clk);
    checkOutput("A data held", doutA, INIT_A);
    checkOutput("B data held", doutB, 64'h1234);

    // Full clear from RUN, with ignored accesses during the fill.
    idle(1);
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    we = 1'b1; be = 8'hFF; waddr = 8'd3; din = 64'hBAD0_BAD0_BAD0_BAD0; re = 1'b1; raddr = 8'd3;
    measureClear(50, cA, cB);
    checkOutput("clr cycles A", 64'(cA), 64'd200);
    checkOutput("clr cycles B", 64'(cB), 64'd256);
    readAllInit();

    // Read issued on the clr cycle completes; second clr at cnt=100 restarts the fill.
    applyStimulus(1'b1, 8'hFF, 8'd7, 64'h77, 1'b0, 8'd0, 64'h0, 1'b0, 64'h0, 1'b0);
    @(posedge clk);
    #1;
    we = 1'b0; clr = 1'b1; re = 1'b1; raddr = 8'd7;
    pushExp(64'h77, 1'b0, 64'h77, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b0; re = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("mid-clear readyA", 64'(readyA), 64'h0);
    checkOutput("mid-clear readyB", 64'(readyB), 64'h0);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    measureClear(0, cA, cB);
    checkOutput("restarted clr cycles A", 64'(cA), 64'd200);
    checkOutput("restarted clr cycles B", 64'(cB), 64'd256);
    applyStimulus(1'b0, 8'h00, 8'd0, 64'h0, 1'b1, 8'd7, INIT_A, 1'b0, INIT_B, 1'b0);

    idle(5);
    checkOutput("A scoreboard drained", 64'(qA.size()), 64'h0);
    checkOutput("B scoreboard drained", 64'(qB.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tp_mem_1r1w_be_init.md
# tp_mem_1r1w_be_init

Parametrised single-clock two-port (1 read, 1 write) RAM with per-byte write enables, selectable read-during-write semantics, an optional output register stage and a built-in clear engine that fills the array with a constant after reset or on request. It is the general-purpose successor to the fixed-size two-port memories. Table, buffer and FIFO blocks instantiate it wherever storage needs a known initial state without a separate init pass.

## Interface
- DATA_W, 64, data width in bits; must be a multiple of BYTE_W
- BYTE_W, 8, bits per write-enable lane
- ADDR_W, 8, address width
- DEPTH, 256, number of words; 1 ≤ DEPTH ≤ 2**ADDR_W
- OUT_REG, 0, 1 adds one output pipeline register
- BYPASS, 1, 1 = write-first on same-address collision; 0 = read-first
- INIT_VAL, 0, DATA_W-bit fill value written by the clear engine
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  request a full re-clear of the array
- ready  out  1  1 when the array is usable
- we  in  1  write enable
- be  in  DATA_W/BYTE_W  byte-lane write enables
- waddr  in  ADDR_W  write address
- data_in  in  DATA_W  write data
- re  in  1  read enable
- raddr  in  ADDR_W  read address
- data_out  out  DATA_W  read data, held between reads
- valid_out  out  1  data_out updated this cycle
- collision  out  1  the read now presented hit a same-cycle write

## Operation
- The FSM has two states, INIT and RUN. rst forces INIT with the fill counter at 0.
- INIT:
  - Writes INIT_VAL to address cnt each cycle; cnt increments by 1.
  - After writing DEPTH-1, the next state is RUN.
  - ready=0. we and re are ignored, so valid_out and collision stay 0.
- RUN:
  - ready=1.
  - clr=1 moves to INIT with cnt=0. The cycle asserting clr still executes its write and read normally.
- clr during INIT restarts cnt at 0.
- Write (RUN, we=1, waddr<DEPTH): lanes with be[i]=1 take data_in[i*BYTE_W +: BYTE_W]; other lanes are unchanged. be=0 is a no-op.
- Read (RUN, re=1): returns the word at raddr. raddr≥DEPTH returns INIT_VAL with valid_out=1. When no read is issued, data_out holds its last value.
- Collision (RUN, re=we=1, raddr==waddr<DEPTH):
  - BYPASS=1 returns the stored word with the be-selected lanes replaced by data_in.
  - BYPASS=0 returns the pre-write word.
  - collision=1, aligned with that read's valid_out.
- Writes with waddr≥DEPTH are dropped.

## Timing
- Reset values: data_out=0, valid_out=0, collision=0, ready=0. The array contents are not reset; the clear engine covers them.
- Clear duration is exactly DEPTH cycles. ready rises on the cycle after the last fill write, so the first access is possible DEPTH cycles after rst deasserts.
- Read latency:
  - OUT_REG=0: 1 cycle. data_out, valid_out and collision update on the posedge sampling re.
  - OUT_REG=1: 2 cycles. The pipeline register also carries valid and collision.
- Full throughput: one read and one write per cycle, no stalls in RUN.
- A write is visible to a read issued on any later cycle. Same-cycle visibility follows BYPASS.
- With OUT_REG=1, a read in flight when INIT is entered still completes on schedule.
- rst mid-operation: all outputs return to reset values immediately and the in-flight read is discarded.

## Structure
- Package tp_mem_pkg holds:
  - the state enum {INIT, RUN};
  - the function expanding be to a DATA_W bit mask;
  - the function merging old and new data under that mask.
- Sub-module tp_mem_core is a plain byte-enabled 1r1w array (DATA_W, BYTE_W, ADDR_W, DEPTH) with a registered read port. It has no reset.
- The clear FSM, write mux (fill vs. user), collision detect/merge and output stage live in the top module.

## Test plan
- Reset release, DEPTH=256: ready=0 for 256 cycles, then 1. A read of every address returns INIT_VAL=0.
- Write 0x1122334455667788 to address 5 with be=0xFF, then be=0x0F with data 0xAAAAAAAAAAAAAAAA. A read of 5 returns 0x11223344AAAAAAAA one cycle later (two with OUT_REG=1).
- Same-cycle re/we at address 9 (old 0x0, new 0xDEAD, be=0xFF): BYPASS=1 gives data_out=0xDEAD, collision=1; BYPASS=0 gives 0x0, collision=1.
- Back-to-back reads of addresses 0..7 with OUT_REG=1: eight consecutive valid_out pulses starting 2 cycles after the first re, data in order.
- Assert clr in RUN after filling the array. Check ready drops for DEPTH cycles and all words read INIT_VAL afterwards. Assert clr again at cnt=100: the clear restarts and ready rises DEPTH cycles after that second clr.
- DEPTH=200, ADDR_W=8: a write to 250 has no effect, and a read of 250 returns INIT_VAL with valid_out=1.
